// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter sharing one BRAM port: playback reader (priority) and synth writer,
// with bounded write starvation. Optional contention counter enabled by BRAM_ARB_STATS_EN.
module bram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int INIT_CYC   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  wr_req,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  output logic                  wr_gnt,
  output logic [ADDR_W-1:0]     BRAM_addr,
  output logic [DATA_W-1:0]     BRAM_din,
  output logic                  BRAM_en,
  output logic [DATA_W/8-1:0]   BRAM_we,
  output logic                  BRAM_rst,
  output logic                  BRAM_clk,
  input  logic [DATA_W-1:0]     BRAM_dout,
  output logic [15:0]           conflict_cnt
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(STARVE_MAX + 1);
  localparam int IW   = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       init_cnt_q, init_cnt_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                rd_gnt_c, wr_gnt_c;
  logic                en_q, en_d;
  logic [BE_W-1:0]     we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [1:0]          rd_pipe_q, rd_pipe_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    starve_d   = starve_q;
    rd_gnt_c   = 1'b0;
    wr_gnt_c   = 1'b0;
    en_d       = 1'b0;
    we_d       = '0;
    addr_d     = addr_q;
    din_d      = din_q;

    if (state_q == ST_INIT) begin
      if (init_cnt_q == IW'(INIT_CYC - 1)) begin
        state_d = ST_RUN;
      end else begin
        init_cnt_d = init_cnt_q + IW'(1);
      end
    end else begin
      // Reader wins unless the writer has already lost STARVE_MAX times in a row.
      rd_gnt_c = rd_req && !((starve_q == SW'(STARVE_MAX)) && wr_req);
      wr_gnt_c = wr_req && !rd_gnt_c;

      if (wr_gnt_c || !wr_req) begin
        starve_d = '0;
      end else if (rd_gnt_c) begin
        starve_d = starve_q + SW'(1);
      end

      if (wr_gnt_c) begin
        en_d   = 1'b1;
        we_d   = wr_be;
        addr_d = wr_addr;
        din_d  = wr_data;
      end else if (rd_gnt_c) begin
        en_d   = 1'b1;
        addr_d = rd_addr;
      end
    end

    // Read return: BRAM_en in N+1, BRAM_dout valid in N+2, registered out in N+3.
    rd_pipe_d  = {rd_pipe_q[0], rd_gnt_c};
    rd_valid_d = rd_pipe_q[1];
    rd_data_d  = rd_pipe_q[1] ? BRAM_dout : rd_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      starve_q   <= '0;
      en_q       <= 1'b0;
      we_q       <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      rd_pipe_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      starve_q   <= starve_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rd_pipe_q  <= rd_pipe_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_gnt    = rd_gnt_c;
  assign wr_gnt    = wr_gnt_c;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign BRAM_en   = en_q;
  assign BRAM_we   = we_q;
  assign BRAM_addr = addr_q;
  assign BRAM_din  = din_q;
  assign BRAM_rst  = (state_q == ST_INIT);
  assign BRAM_clk  = clk;

`ifdef BRAM_ARB_STATS_EN
  logic [15:0] conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else if ((state_q == ST_RUN) && rd_req && wr_req && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, width of all data ports; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_MAX, default 8, maximum consecutive read grants while a write waits.
REQ-004 SHALL have parameter INIT_CYC, default 4, number of BRAM_rst cycles after reset.
REQ-005 SHALL have ports, as name / direction / width / meaning:
- clk  in  1  system clock, the PL fabric clock.
- rst  in  1  asynchronous, active-high reset.
- rd_req  in  1  read request from the playback reader (requester 0).
- rd_addr  in  ADDR_W  read byte address.
- rd_gnt  out  1  read accepted this cycle.
- rd_data  out  DATA_W  returned read word.
- rd_valid  out  1  rd_data valid, one-cycle pulse.
- wr_req  in  1  write request from the synth writer (requester 1).
- wr_addr  in  ADDR_W  write byte address.
- wr_data  in  DATA_W  write word.
- wr_be  in  DATA_W/8  byte enables.
- wr_gnt  out  1  write accepted this cycle.
- BRAM_addr, BRAM_din, BRAM_en, BRAM_we, BRAM_rst  out  ADDR_W / DATA_W / 1 / DATA_W/8 / 1  shared BRAM port drive.
- BRAM_clk  out  1  equal to clk.
- BRAM_dout  in  DATA_W  BRAM read data, 1-cycle latency after BRAM_en.
- conflict_cnt  out  16  contention statistic (see Configuration).

Function
REQ-006 SHALL implement states INIT and RUN; INIT holds BRAM_rst=1 for INIT_CYC cycles, grants nothing, then goes to RUN; RUN is never left except by reset.
REQ-007 SHALL use a req/gnt handshake: the requester holds req and payload stable until gnt; the transfer is accepted on the rising edge where gnt=1; gnt is combinational from req and state, with at most one gnt per cycle.
REQ-008 SHALL grant the reader when rd_req=1, unless the starvation counter equals STARVE_MAX and wr_req=1, in which case it grants the writer.
REQ-009 SHALL increment the starvation counter on each read grant while wr_req=1, and clear it on a write grant or while wr_req=0.
REQ-010 SHALL register the granted access onto BRAM_* in cycle N+1 for a gnt in cycle N: BRAM_en=1, BRAM_we=wr_be for a write and 0 for a read; otherwise BRAM_en=0 and BRAM_we=0.
REQ-011 SHALL register BRAM_dout into rd_data and pulse rd_valid in cycle N+3 for a read granted in cycle N; rd_data holds its value until the next rd_valid.
REQ-012 SHALL sustain one grant per cycle with back-to-back requests and no bubbles.
REQ-013 SHALL preserve grant order at the BRAM port, so a read granted after a write to the same address returns the new data.

Reset
REQ-014 SHALL, while rst=1, force state=INIT, both counters=0, rd_gnt=wr_gnt=0, rd_valid=0, rd_data=0, BRAM_en=0, BRAM_we=0, BRAM_addr=0, BRAM_din=0, BRAM_rst=1 and conflict_cnt=0.
REQ-015 SHALL discard reads in flight when reset is asserted, with no rd_valid pulse after reset release for a read issued before it.

Configuration
REQ-016 SHALL, with BRAM_ARB_STATS_EN defined, increment conflict_cnt by one, saturating at 0xFFFF, in each RUN cycle where rd_req=wr_req=1.
REQ-017 SHALL, without BRAM_ARB_STATS_EN, tie conflict_cnt to 0 and include no counter logic.

Verification
REQ-018 SHALL cover reset release → BRAM_rst=1 for exactly 4 cycles with no grants; then a single read of 0x10 → rd_gnt in cycle N, BRAM_en/addr=0x10 in N+1, rd_valid in N+3 with the stored word.
REQ-019 SHALL cover rd_req and wr_req held high for 20 cycles (STARVE_MAX=8) → grant pattern of 8 reads, 1 write, repeating; conflict_cnt=20 with the stats macro, 0 without it.
REQ-020 SHALL cover a write of 0xDEADBEEF with be=0x3 to 0x40 granted, then a read of 0x40 → low 16 bits updated and high 16 bits unchanged.
REQ-021 SHALL cover rst asserted one cycle after a read grant → no rd_valid afterwards and all outputs at their reset values.
REQ-022 SHALL cover conflict_cnt preloaded near saturation plus a continuous conflict → the value holds at 0xFFFF.
